// File: rtl/yuv422_packer.sv
// yuv422_packer: 24-bit 4:4:4 YCbCr to 16-bit 4:2:2 {C,Y} for the ADV7511.
// Two input stages plus output registers give a fixed 3-cycle latency.
module yuv422_packer #(
  parameter int          FILTER      = 1,
  parameter logic [15:0] BLANK_VALUE = 16'h8010
) (
  input  logic        sys2_clk,
  input  logic        sys2_rst,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [23:0] in_data,
  input  logic        clr,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [15:0] out_data,
  output logic        odd_len
);

  logic        r_s1_de, r_s1_hs, r_s1_vs;
  logic [23:0] r_s1_data;
  logic        r_s2_de, r_s2_hs, r_s2_vs;
  logic [23:0] r_s2_data;
  logic        r_phase;
  logic [7:0]  r_hold_cr;
  logic        r_de, r_hs, r_vs, r_odd;
  logic [15:0] r_data;

  logic [7:0]  w_cb_avg, w_cr_avg;
  logic [7:0]  w_c, w_hold_nxt;
  logic        w_set;
  logic [15:0] w_data;

  assign w_cb_avg = 8'((9'(r_s2_data[15:8])
                      + 9'(r_s1_data[15:8])
                      + 9'd1) >> 1);
  assign w_cr_avg = 8'((9'(r_s2_data[23:16])
                      + 9'(r_s1_data[23:16])
                      + 9'd1) >> 1);

  // Phase 0 pixel emits Cb and latches Cr for its odd partner.
  always_comb begin
    w_c        = r_s2_data[15:8];
    w_hold_nxt = r_hold_cr;
    w_set      = 1'b0;
    if (r_s2_de) begin
      if (r_phase) begin
        w_c = r_hold_cr;
      end else if (r_s1_de) begin
        if (FILTER != 0) begin
          w_c        = w_cb_avg;
          w_hold_nxt = w_cr_avg;
        end else begin
          w_hold_nxt = r_s2_data[23:16];
        end
      end else begin
        w_set = 1'b1;
      end
    end
  end

  assign w_data = r_s2_de ? {w_c, r_s2_data[7:0]} : BLANK_VALUE;

  always_ff @(posedge sys2_clk or posedge sys2_rst) begin
    if (sys2_rst) begin
      r_s1_de   <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
      r_s1_data <= '0;
      r_s2_de   <= 1'b0;
      r_s2_hs   <= 1'b0;
      r_s2_vs   <= 1'b0;
      r_s2_data <= '0;
      r_phase   <= 1'b0;
      r_hold_cr <= '0;
      r_de      <= 1'b0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_data    <= BLANK_VALUE;
      r_odd     <= 1'b0;
    end else begin
      r_s1_de   <= in_de;
      r_s1_hs   <= in_hs;
      r_s1_vs   <= in_vs;
      r_s1_data <= in_data;
      r_s2_de   <= r_s1_de;
      r_s2_hs   <= r_s1_hs;
      r_s2_vs   <= r_s1_vs;
      r_s2_data <= r_s1_data;
      r_phase   <= r_s2_de ? ~r_phase : 1'b0;
      r_hold_cr <= w_hold_nxt;
      r_de      <= r_s2_de;
      r_hs      <= r_s2_hs;
      r_vs      <= r_s2_vs;
      r_data    <= w_data;
      if (w_set)
        r_odd <= 1'b1;
      else if (clr)
        r_odd <= 1'b0;
    end
  end

  assign out_de   = r_de;
  assign out_hs   = r_hs;
  assign out_vs   = r_vs;
  assign out_data = r_data;
  assign odd_len  = r_odd;

endmodule

// File: tb/tb_yuv422_packer.sv
// tb_yuv422_packer: random and directed stimulus for both FILTER settings,
// checked every cycle against a run-position model of the 4:2:2 packing.
module tb_yuv422_packer;

  localparam logic [15:0] BLANK = 16'h8010;
  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de = 1'b0, hs = 1'b0, vs = 1'b0, clr = 1'b0;
  logic [23:0] data = '0;

  logic        de1, hs1, vs1, odd1;
  logic        de0, hs0, vs0, odd0;
  logic [15:0] d1, d0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  yuv422_packer #(.FILTER(1), .BLANK_VALUE(16'h8010)) u_f1 (
    .sys2_clk(clk), .sys2_rst(rst),
    .in_de(de), .in_hs(hs), .in_vs(vs), .in_data(data), .clr(clr),
    .out_de(de1), .out_hs(hs1), .out_vs(vs1),
    .out_data(d1), .odd_len(odd1)
  );

  yuv422_packer #(.FILTER(0), .BLANK_VALUE(16'h8010)) u_f0 (
    .sys2_clk(clk), .sys2_rst(rst),
    .in_de(de), .in_hs(hs), .in_vs(vs), .in_data(data), .clr(clr),
    .out_de(de0), .out_hs(hs0), .out_vs(vs0),
    .out_data(d0), .odd_len(odd0)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Input history: what the DUT actually captured at each edge.
  logic        h_de[N];
  logic        h_hs[N];
  logic        h_vs[N];
  logic [23:0] h_d[N];
  int          h_pos[N];
  int          cyc = 0;

  function automatic logic gde(int i);
    return (i >= 0) ? h_de[i] : 1'b0;
  endfunction
  function automatic logic ghs(int i);
    return (i >= 0) ? h_hs[i] : 1'b0;
  endfunction
  function automatic logic gvs(int i);
    return (i >= 0) ? h_vs[i] : 1'b0;
  endfunction
  function automatic logic [23:0] gd(int i);
    return (i >= 0) ? h_d[i] : 24'h0;
  endfunction
  function automatic int gpos(int i);
    return (i >= 0) ? h_pos[i] : -1;
  endfunction

  function automatic logic [7:0] avg(input logic [7:0] x, input logic [7:0] y);
    int s;
    s = (int'(x) + int'(y) + 1) / 2;
    return s[7:0];
  endfunction

  // Output for the pixel captured at edge a, whose successor is at a+1.
  function automatic logic [15:0] mdl(int f, int a);
    logic [23:0] p, q, r;
    logic [7:0]  c;
    p = gd(a);
    q = gd(a + 1);
    r = gd(a - 1);
    if (!gde(a)) return BLANK;
    if (gpos(a) % 2 == 0) begin
      if (gde(a + 1) && f == 1) c = avg(p[15:8], q[15:8]);
      else c = p[15:8];
    end else begin
      if (f == 1) c = avg(r[23:16], p[23:16]);
      else c = r[23:16];
    end
    return {c, p[7:0]};
  endfunction

  logic        e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_odd = 1'b0;
  logic [15:0] e_d[2];

  initial begin
    e_d[0] = BLANK;
    e_d[1] = BLANK;
    forever begin
      @(posedge clk);
      if (cyc >= N) begin
        $display("FAIL model_history: got %0d expected below %0d", cyc, N);
        $fatal(1, "history overflow");
      end
      if (rst) begin
        for (int j = 0; j < 3; j++) begin
          if (cyc - j >= 0) begin
            h_de[cyc - j]  = 1'b0;
            h_hs[cyc - j]  = 1'b0;
            h_vs[cyc - j]  = 1'b0;
            h_d[cyc - j]   = '0;
            h_pos[cyc - j] = -1;
          end
        end
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_odd = 1'b0;
        e_d[0] = BLANK;
        e_d[1] = BLANK;
      end else begin
        h_de[cyc]  = de;
        h_hs[cyc]  = hs;
        h_vs[cyc]  = vs;
        h_d[cyc]   = data;
        h_pos[cyc] = de ? gpos(cyc - 1) + 1 : -1;
        e_de = gde(cyc - 2);
        e_hs = ghs(cyc - 2);
        e_vs = gvs(cyc - 2);
        for (int f = 0; f < 2; f++) e_d[f] = mdl(f, cyc - 2);
        if (gde(cyc - 2) && (gpos(cyc - 2) % 2 == 0) && !gde(cyc - 1))
          e_odd = 1'b1;
        else if (clr)
          e_odd = 1'b0;
      end
      cyc = cyc + 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_de1", 32'(de1), 32'(0));
      chk("rst_d1", 32'(d1), 32'(BLANK));
      chk("rst_d0", 32'(d0), 32'(BLANK));
      chk("rst_odd1", 32'(odd1), 32'(0));
    end else begin
      chk("de1", 32'(de1), 32'(e_de));
      chk("hs1", 32'(hs1), 32'(e_hs));
      chk("vs1", 32'(vs1), 32'(e_vs));
      chk("de0", 32'(de0), 32'(e_de));
      chk("hs0", 32'(hs0), 32'(e_hs));
      chk("vs0", 32'(vs0), 32'(e_vs));
      chk("data_f1", 32'(d1), 32'(e_d[1]));
      chk("data_f0", 32'(d0), 32'(e_d[0]));
      chk("odd_f1", 32'(odd1), 32'(e_odd));
      chk("odd_f0", 32'(odd0), 32'(e_odd));
    end
  end

  logic [15:0] q1[$];
  logic [15:0] q0[$];

  initial forever begin
    @(negedge clk);
    if (de1) q1.push_back(d1);
    if (de0) q0.push_back(d0);
  end

  task automatic drv(input logic d, input logic h, input logic v,
                     input logic [23:0] x, input logic c);
    de = d; hs = h; vs = v; data = x; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) drv(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
  endtask

  task automatic qchk(input string name, input logic [15:0] exp[$],
                      input logic f);
    chk({name, "_len"}, 32'(f ? q1.size() : q0.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(name, 32'(f ? (i < q1.size() ? q1[i] : 16'h0)
                      : (i < q0.size() ? q0[i] : 16'h0)), 32'(exp[i]));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_data", 32'(d1), 32'(BLANK));
    idle(2);

    q1.delete(); q0.delete();
    drv(1, 0, 0, 24'h302010, 0);
    drv(1, 0, 0, 24'h322212, 0);
    drv(1, 0, 0, 24'h342414, 0);
    drv(1, 0, 0, 24'h362616, 0);
    idle(4);
    qchk("t1_f1", '{16'h2110, 16'h3112, 16'h2514, 16'h3516}, 1'b1);
    qchk("t2_f0", '{16'h2010, 16'h3012, 16'h2414, 16'h3416}, 1'b0);
    chk("t1_odd", 32'(odd1), 32'(0));

    q1.delete(); q0.delete();
    drv(1, 0, 0, 24'h00FFEB, 0);
    drv(1, 0, 0, 24'h01FEEB, 0);
    idle(4);
    qchk("t3_round", '{16'hFFEB, 16'h01EB}, 1'b1);

    q1.delete(); q0.delete();
    drv(1, 0, 0, 24'h504011, 0);
    drv(1, 0, 0, 24'h706022, 0);
    drv(1, 0, 0, 24'hA09033, 0);
    idle(4);
    qchk("t4_odd_run", '{16'h5011, 16'h6022, 16'h9033}, 1'b1);
    chk("t4_odd_set", 32'(odd1), 32'(1));
    drv(0, 0, 0, 24'h0, 1);
    chk("t4_odd_clr", 32'(odd1), 32'(0));
    idle(2);

    for (int line = 0; line < 2; line++)
      for (int h = 0; h < 2200; h++)
        drv(h < 1920, h >= 2008 && h < 2052, line == 0 && h >= 2100,
            24'($urandom), 1'b0);
    idle(4);

    for (int i = 0; i < 7; i++) drv(1, 1, 1, 24'($urandom), 0);
    de = 1'b1; data = 24'($urandom);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_de", 32'(de1), 32'(0));
    chk("t6_rst_hs", 32'(hs1), 32'(0));
    chk("t6_rst_vs", 32'(vs0), 32'(0));
    chk("t6_rst_d1", 32'(d1), 32'(BLANK));
    chk("t6_rst_d0", 32'(d0), 32'(BLANK));
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    q1.delete(); q0.delete();
    drv(1, 0, 0, 24'hC0A0F1, 0);
    drv(1, 0, 0, 24'hE0B0F2, 0);
    idle(4);
    qchk("t6_first_f1", '{16'hA8F1, 16'hD0F2}, 1'b1);
    qchk("t6_first_f0", '{16'hA0F1, 16'hC0F2}, 1'b0);
    chk("t6_odd_pre", 32'(odd1), 32'(0));
    drv(1, 0, 0, 24'h123456, 0);
    drv(0, 0, 0, 24'h0, 0);
    drv(0, 0, 0, 24'h0, 1);
    chk("t6_set_wins", 32'(odd1), 32'(1));
    idle(2);

    for (int i = 0; i < 3000; i++)
      drv($urandom_range(0, 99) < 70, $urandom_range(0, 19) == 0,
          $urandom_range(0, 49) == 0, 24'($urandom),
          $urandom_range(0, 15) == 0);
    for (int i = 0; i < 51; i++) drv(1, 0, 0, 24'($urandom), 0);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
